bus_xfer_sequencer: RTL and testbench

BUS_XFER_SEQUENCER -- requirements
Module: bus_xfer_sequencer

---
 rtl/bus_xfer_sequencer_if.sv | 24 ++
 rtl/bus_xfer_sequencer.sv | 131 +++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_xfer_sequencer_if.sv
// Request handshake and bus-control signals of the transfer sequencer.
// The master side issues {src, dest} requests; the slave side (the
// sequencer) drives the bus multiplexer select and destination loads.
interface bus_xfer_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_src;
   logic [4:0]  req_dest;
   logic [4:0]  bus_select;
   logic [19:0] dest_load;
   logic        xfer_done;
   logic        busy;
   logic        err;

   modport master (
      output req_valid, req_src, req_dest,
      input  req_ready, bus_select, dest_load, xfer_done, busy, err
   );

   modport slave (
      input  req_valid, req_src, req_dest,
      output req_ready, bus_select, dest_load, xfer_done, busy, err
   );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: queues {src, dest} requests in a 2-entry
// FIFO and plays each one out as SETTLE (bus select only) followed by
// LOAD (select held, one destination load enable pulsed). Illegal codes
// still walk through SETTLE/LOAD but never load, and latch a sticky err.
module bus_xfer_sequencer (
   input logic                  clock,
   input logic                  clear,
   bus_xfer_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, LOAD} state_t;

   localparam logic [4:0] SEL_ZERO = 5'd31;  // mux input that reads zero

   state_t      state_q, state_d;
   logic [9:0]  mem_q [0:1];
   logic [9:0]  mem_d [0:1];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [4:0]  work_src_q, work_src_d;
   logic [4:0]  work_dest_q, work_dest_d;
   logic [4:0]  bus_select_q, bus_select_d;
   logic [19:0] dest_load_q, dest_load_d;
   logic        xfer_done_q, xfer_done_d;
   logic        err_q, err_d;

   logic        req_ready;
   logic        push;
   logic        pop;
   logic        legal_d;
   logic [9:0]  head;
   logic [19:0] dest_onehot;

   // One-hot decode of the next working destination (codes 20-31 decode to zero)
   for (genvar gi = 0; gi < 20; gi++) begin : g_dest_dec
      assign dest_onehot[gi] = (work_dest_d == 5'(gi));
   end

   // Next-state, FIFO bookkeeping and registered-output computation
   always_comb begin
      req_ready   = (count_q != 2'd2);
      push        = bus.req_valid && req_ready;
      pop         = (count_q != 2'd0) && (state_q == IDLE || state_q == LOAD);
      head        = mem_q[rd_ptr_q];

      mem_d       = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {bus.req_src, bus.req_dest};
      end
      wr_ptr_d    = wr_ptr_q ^ push;
      rd_ptr_d    = rd_ptr_q ^ pop;
      count_d     = count_q + 2'(push) - 2'(pop);

      state_d     = state_q;
      work_src_d  = work_src_q;
      work_dest_d = work_dest_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d     = SETTLE;
               work_src_d  = head[9:5];
               work_dest_d = head[4:0];
            end
         end
         SETTLE: state_d = LOAD;
         LOAD: begin
            if (pop) begin
               state_d     = SETTLE;
               work_src_d  = head[9:5];
               work_dest_d = head[4:0];
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      legal_d      = (work_src_d < 5'd24) && (work_dest_d < 5'd20);

      // Outputs are decoded from the state being entered so they are flop outputs
      bus_select_d = SEL_ZERO;
      dest_load_d  = '0;
      xfer_done_d  = 1'b0;
      case (state_d)
         SETTLE: bus_select_d = work_src_d;
         LOAD: begin
            bus_select_d = work_src_d;
            dest_load_d  = legal_d ? dest_onehot : 20'd0;
            xfer_done_d  = legal_d;
         end
         default: ;
      endcase

      err_d = err_q || (state_d == LOAD && !legal_d);
   end

   // All sequencer state; clear overrides any push or pop in the same cycle
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q      <= IDLE;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         work_src_q   <= 5'd0;
         work_dest_q  <= 5'd0;
         bus_select_q <= SEL_ZERO;
         dest_load_q  <= 20'd0;
         xfer_done_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         work_src_q   <= work_src_d;
         work_dest_q  <= work_dest_d;
         bus_select_q <= bus_select_d;
         dest_load_q  <= dest_load_d;
         xfer_done_q  <= xfer_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.bus_select = bus_select_q;
   assign bus.dest_load  = dest_load_q;
   assign bus.xfer_done  = xfer_done_q;
   assign bus.busy       = (state_q != IDLE) || (count_q != 2'd0);
   assign bus.err        = err_q;
endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed bench for bus_xfer_sequencer: single transfer, back-to-back
// stream, illegal codes, clear mid-transfer, simultaneous push/pop, plus
// a per-cycle invariant monitor on the bus-control outputs.
module tb_bus_xfer_sequencer;
   logic clock = 1'b0;
   logic clear;
   int   checks   = 0;
   int   failures = 0;

   bus_xfer_sequencer_if bus_if ();

   bus_xfer_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus_if.slave)
   );

   always #5 clock = ~clock;

   // Request tables: src, dest and earliest cycle to present each request
   logic [4:0]  tab_src  [0:7];
   logic [4:0]  tab_dest [0:7];
   int          tab_at   [0:7];
   // Output history, index c = values seen just after edge c of a stream
   logic [4:0]  sel_hist  [0:31];
   logic [19:0] dl_hist   [0:31];
   logic        xd_hist   [0:31];
   logic        rdy_hist  [0:31];
   logic        busy_hist [0:31];
   logic        err_hist  [0:31];

   logic        inv_en = 1'b0;
   logic [4:0]  prev_sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present tab entries 0..n-1 with a valid/ready handshake for ncyc edges
   task automatic stream(input int n, input int ncyc);
      int   idx;
      logic rdy;
      idx = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (idx < n && c >= tab_at[idx]) begin
            bus_if.req_valid = 1'b1;
            bus_if.req_src   = tab_src[idx];
            bus_if.req_dest  = tab_dest[idx];
         end else begin
            bus_if.req_valid = 1'b0;
         end
         rdy = bus_if.req_ready;
         tick();
         if (bus_if.req_valid && rdy) idx++;
         sel_hist[c]  = bus_if.bus_select;
         dl_hist[c]   = bus_if.dest_load;
         xd_hist[c]   = bus_if.xfer_done;
         rdy_hist[c]  = bus_if.req_ready;
         busy_hist[c] = bus_if.busy;
         err_hist[c]  = bus_if.err;
      end
      bus_if.req_valid = 1'b0;
      chk("all_pushed", 32'(idx), 32'(n));
   endtask

   // Per-cycle invariants: one-hot load, done == OR(load), select held into LOAD
   always @(negedge clock) begin
      if (inv_en) begin
         chk("inv_onehot", 32'($onehot0(bus_if.dest_load)), 32'd1);
         chk("inv_done_or", 32'(bus_if.xfer_done), 32'(|bus_if.dest_load));
         if (bus_if.dest_load != 20'd0) begin
            chk("inv_sel_stable", 32'(bus_if.bus_select), 32'(prev_sel));
         end
      end
      prev_sel <= bus_if.bus_select;
   end

   initial begin
      int nz;
      bus_if.req_valid = 1'b0;
      bus_if.req_src   = 5'd0;
      bus_if.req_dest  = 5'd0;
      clear = 1'b1;
      tick();
      tick();
      clear = 1'b0;
      inv_en = 1'b1;

      // Reset state
      chk("rst_sel",   32'(bus_if.bus_select), 32'd31);
      chk("rst_dl",    32'(bus_if.dest_load),  32'd0);
      chk("rst_xd",    32'(bus_if.xfer_done),  32'd0);
      chk("rst_busy",  32'(bus_if.busy),       32'd0);
      chk("rst_ready", 32'(bus_if.req_ready),  32'd1);
      chk("rst_err",   32'(bus_if.err),        32'd0);

      // Single transfer MDR -> MAR
      bus_if.req_valid = 1'b1;
      bus_if.req_src   = 5'd21;
      bus_if.req_dest  = 5'd18;
      tick();
      bus_if.req_valid = 1'b0;
      chk("t1_idle_sel",  32'(bus_if.bus_select), 32'd31);
      chk("t1_idle_busy", 32'(bus_if.busy),       32'd1);
      tick();
      chk("t1_settle_sel", 32'(bus_if.bus_select), 32'd21);
      chk("t1_settle_dl",  32'(bus_if.dest_load),  32'd0);
      tick();
      chk("t1_load_sel", 32'(bus_if.bus_select), 32'd21);
      chk("t1_load_dl",  32'(bus_if.dest_load),  32'h40000);
      chk("t1_load_xd",  32'(bus_if.xfer_done),  32'd1);
      tick();
      chk("t1_after_sel",  32'(bus_if.bus_select), 32'd31);
      chk("t1_after_dl",   32'(bus_if.dest_load),  32'd0);
      chk("t1_after_busy", 32'(bus_if.busy),       32'd0);

      // Back-to-back stream: loads after edges 2,4,6,8
      tab_src[0] = 5'd3;  tab_dest[0] = 5'd5;  tab_at[0] = 0;
      tab_src[1] = 5'd16; tab_dest[1] = 5'd0;  tab_at[1] = 0;
      tab_src[2] = 5'd20; tab_dest[2] = 5'd19; tab_at[2] = 0;
      tab_src[3] = 5'd23; tab_dest[3] = 5'd7;  tab_at[3] = 0;
      stream(4, 10);
      chk("t2_ready_full", 32'(rdy_hist[2]), 32'd0);
      chk("t2_dl0",  32'(dl_hist[2]), 32'h00020);
      chk("t2_sel0", 32'(sel_hist[2]), 32'd3);
      chk("t2_gap",  32'(dl_hist[3]), 32'd0);
      chk("t2_dl1",  32'(dl_hist[4]), 32'h00001);
      chk("t2_sel1", 32'(sel_hist[4]), 32'd16);
      chk("t2_dl2",  32'(dl_hist[6]), 32'h80000);
      chk("t2_sel2", 32'(sel_hist[6]), 32'd20);
      chk("t2_dl3",  32'(dl_hist[8]), 32'h00080);
      chk("t2_sel3", 32'(sel_hist[8]), 32'd23);
      chk("t2_idle_busy", 32'(busy_hist[9]), 32'd0);

      // Illegal src, then illegal dest
      tab_src[0] = 5'd25; tab_dest[0] = 5'd2;  tab_at[0] = 0;
      tab_src[1] = 5'd1;  tab_dest[1] = 5'd30; tab_at[1] = 0;
      stream(2, 6);
      nz = 0;
      for (int c = 0; c < 6; c++) begin
         if (dl_hist[c] != 20'd0 || xd_hist[c]) nz++;
      end
      chk("t3_no_loads",   32'(nz), 32'd0);
      chk("t3_settle_sel", 32'(sel_hist[1]), 32'd25);
      chk("t3_err_settle", 32'(err_hist[1]), 32'd0);
      chk("t3_load_sel",   32'(sel_hist[2]), 32'd25);
      chk("t3_err_load",   32'(err_hist[2]), 32'd1);
      chk("t3_sel_2nd",    32'(sel_hist[4]), 32'd1);
      for (int i = 0; i < 10; i++) tick();
      chk("t3_err_sticky", 32'(bus_if.err), 32'd1);

      // Clear during the LOAD of the first of three queued requests
      tab_src[0] = 5'd2; tab_dest[0] = 5'd3; tab_at[0] = 0;
      tab_src[1] = 5'd4; tab_dest[1] = 5'd5; tab_at[1] = 0;
      tab_src[2] = 5'd6; tab_dest[2] = 5'd8; tab_at[2] = 0;
      stream(3, 3);
      chk("t4_load_dl",  32'(dl_hist[2]),  32'h00008);
      chk("t4_load_sel", 32'(sel_hist[2]), 32'd2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t4_clr_dl",    32'(bus_if.dest_load),  32'd0);
      chk("t4_clr_busy",  32'(bus_if.busy),       32'd0);
      chk("t4_clr_ready", 32'(bus_if.req_ready),  32'd1);
      chk("t4_clr_sel",   32'(bus_if.bus_select), 32'd31);
      chk("t4_clr_err",   32'(bus_if.err),        32'd0);
      nz = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus_if.dest_load != 20'd0 || bus_if.busy) nz++;
      end
      chk("t4_quiet", 32'(nz), 32'd0);

      // Push during LOAD while one entry is queued (push and pop together)
      tab_src[0] = 5'd1; tab_dest[0] = 5'd1; tab_at[0] = 0;
      tab_src[1] = 5'd2; tab_dest[1] = 5'd2; tab_at[1] = 1;
      tab_src[2] = 5'd9; tab_dest[2] = 5'd9; tab_at[2] = 3;
      stream(3, 9);
      chk("t5_first_dl",  32'(dl_hist[2]),  32'h00002);
      chk("t5_ready_pp",  32'(rdy_hist[3]), 32'd1);
      chk("t5_settle_b",  32'(sel_hist[3]), 32'd2);
      chk("t5_load_b",    32'(dl_hist[4]),  32'h00004);
      chk("t5_settle_c",  32'(sel_hist[5]), 32'd9);
      chk("t5_load_c",    32'(dl_hist[6]),  32'h00200);
      chk("t5_idle_busy", 32'(busy_hist[7]), 32'd0);

      inv_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
